// File: rtl/debug_uart_rx_pkg.sv
// Shared types for the debug console receive path.
package debug_uart_rx_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

endpackage

// File: rtl/debug_uart_rx_if.sv
// Byte stream from the receive FIFO to debug_core (valid/ready handshake).
interface debug_uart_rx_if;
    import debug_uart_rx_pkg::*;

    logic              fifo_rx_vld;
    logic              fifo_rx_rdy;
    logic [DATA_W-1:0] fifo_rx_dat;

    modport master (
        output fifo_rx_vld,
        output fifo_rx_dat,
        input  fifo_rx_rdy
    );

    modport slave (
        input  fifo_rx_vld,
        input  fifo_rx_dat,
        output fifo_rx_rdy
    );
endinterface

// File: rtl/debug_uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; dout always shows the head entry.
module debug_rx_fifo #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned PW    = (FIFO_AW > 0) ? FIFO_AW : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [FIFO_AW:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (FIFO_AW + 1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/debug_uart_rx.sv
// 8N1 UART receiver for the debug console, feeding debug_core through a small FIFO.
module debug_uart_rx
    import debug_uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned FIFO_AW   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            uart_rx,
    debug_uart_rx_if.master rx,
    output logic            frame_err,
    output logic            overflow
);
    localparam int unsigned DIV = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);

    if (DIV < 8) begin : g_div_check
        $error("debug_uart_rx: CLK_FREQ/BAUD_RATE must be at least 8");
    end

    logic [1:0]        sync;
    logic              rxs;
    rx_state_t         state;
    logic [CW-1:0]     cnt;
    logic [2:0]        idx;
    logic [DATA_W-1:0] sh;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[0], uart_rx};
        end
    end
    assign rxs = sync[1];

    // Bits are sampled at their centre: DIV/2 after the start edge, then every DIV.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RX_IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            push      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            push      <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (!rxs) begin
                        state <= RX_START;
                        cnt   <= CNT_HALF;
                    end
                end
                RX_START: begin
                    if (cnt == '0) begin
                        if (!rxs) begin
                            state <= RX_DATA;
                            cnt   <= CNT_FULL;
                            idx   <= '0;
                        end else begin
                            state <= RX_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == '0) begin
                        sh  <= {rxs, sh[DATA_W-1:1]};
                        cnt <= CNT_FULL;
                        if (idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == '0) begin
                        if (rxs) begin
                            push  <= 1'b1;
                            state <= RX_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= RX_BREAK;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RX_BREAK: begin
                    if (rxs) begin
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    assign pop = rx.fifo_rx_vld & rx.fifo_rx_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else begin
            overflow <= push & full & ~pop;
        end
    end

    debug_rx_fifo #(
        .WIDTH   (DATA_W),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (sh),
        .full  (full),
        .pop   (pop),
        .dout  (rx.fifo_rx_dat),
        .empty (empty)
    );

    assign rx.fifo_rx_vld = ~empty;
endmodule
